// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder with valid/ready handshake.
// Result is {carry_out, sum} of i_add1 + i_add2 + i_cin, WIDTH+1 bits.
// Carries come from per-bit generate/propagate folded into per-group G/P,
// with the group carry chain as the only path between groups.
// STAGES selects 1, 2 or 3 register stages from input to output.
// Optional feature: define CLA_PIPE_OVF_EN to add the o_ovf signed-overflow
// output, registered alongside o_result.
module cla_pipe_adder #(
    parameter int WIDTH  = 11,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    // Number of lookahead groups; the top group may be narrower than GROUP.
    localparam int NG = (WIDTH + GROUP - 1) / GROUP;

    // Group carries: gc[0] is the carry-in, gc[k+1] = G[k] | P[k] & gc[k].
    function automatic logic [NG:0] f_group_carry(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input logic             cin
    );
        logic [NG:0] gc;
        logic        grp_g;
        logic        grp_p;
        // NOTE: every local starts from a known value so no path leaves a bit
        // unassigned; in combinational code that is what keeps latches out.
        gc    = '0;
        gc[0] = cin;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            grp_g = g[i] | (p[i] & grp_g);
            grp_p = grp_p & p[i];
            if ((i % GROUP == GROUP - 1) || (i == WIDTH - 1)) begin
                gc[i / GROUP + 1] = grp_g | (grp_p & gc[i / GROUP]);
                grp_g = 1'b0;
                grp_p = 1'b1;
            end
        end
        return gc;
    endfunction

    // Bit carries: each group starts from its lookahead carry and only
    // ripples inside the group; the carry-out is the last group carry.
    function automatic logic [WIDTH:0] f_bit_carry(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input logic [NG:0]      gc
    );
        logic [WIDTH:0] c;
        c    = '0;
        c[0] = gc[0];
        for (int i = 0; i < WIDTH; i++) begin
            if ((i + 1) % GROUP == 0)
                c[i + 1] = gc[(i + 1) / GROUP];
            else
                c[i + 1] = g[i] | (p[i] & c[i]);
        end
        c[WIDTH] = gc[NG];
        return c;
    endfunction

    logic             r_valid;
    logic [WIDTH:0]   r_result;
    logic             w_advance;
    logic             w_last_valid;
    logic [WIDTH:0]   w_result_next;
`ifdef CLA_PIPE_OVF_EN
    logic             r_ovf;
    logic             w_ovf_next;
`endif

    // The whole pipe moves as one: it advances unless a held result blocks it.
    assign w_advance = i_ready | ~r_valid;
    assign o_ready   = w_advance;

    generate
        if (STAGES == 1) begin : g_st1
            logic [WIDTH-1:0] w_g;
            logic [WIDTH-1:0] w_p;
            logic [WIDTH-1:0] w_x;
            logic [NG:0]      w_gc;
            logic [WIDTH:0]   w_c;

            assign w_g           = i_add1 & i_add2;
            assign w_p           = i_add1 | i_add2;
            assign w_x           = i_add1 ^ i_add2;
            assign w_gc          = f_group_carry(w_g, w_p, i_cin);
            assign w_c           = f_bit_carry(w_g, w_p, w_gc);
            assign w_result_next = {w_c[WIDTH], w_x ^ w_c[WIDTH-1:0]};
            assign w_last_valid  = i_valid;
`ifdef CLA_PIPE_OVF_EN
            assign w_ovf_next    = w_c[WIDTH] ^ w_c[WIDTH-1];
`endif
        end else begin : g_multi
            logic             r_s1_valid;
            logic [WIDTH-1:0] r_s1_g;
            logic [WIDTH-1:0] r_s1_p;
            logic [WIDTH-1:0] r_s1_x;
            logic             r_s1_cin;

            // Stage 1: capture per-bit generate, propagate, half-sum and carry-in.
            always_ff @(posedge i_clk) begin
                // NOTE: sequential state uses <= so every register samples the
                // pre-edge value of the others, whatever the statement order.
                if (i_rst) begin
                    r_s1_valid <= 1'b0;
                end else if (w_advance) begin
                    // NOTE: only the valid bit needs reset; datapath registers
                    // behind a cleared valid are never observed.
                    r_s1_valid <= i_valid;
                    r_s1_g     <= i_add1 & i_add2;
                    r_s1_p     <= i_add1 | i_add2;
                    r_s1_x     <= i_add1 ^ i_add2;
                    r_s1_cin   <= i_cin;
                end
            end

            if (STAGES == 2) begin : g_st2
                logic [NG:0]    w_gc;
                logic [WIDTH:0] w_c;

                assign w_gc          = f_group_carry(r_s1_g, r_s1_p, r_s1_cin);
                assign w_c           = f_bit_carry(r_s1_g, r_s1_p, w_gc);
                assign w_result_next = {w_c[WIDTH], r_s1_x ^ w_c[WIDTH-1:0]};
                assign w_last_valid  = r_s1_valid;
`ifdef CLA_PIPE_OVF_EN
                assign w_ovf_next    = w_c[WIDTH] ^ w_c[WIDTH-1];
`endif
            end else begin : g_st3
                logic             r_s2_valid;
                logic [NG:0]      r_s2_gc;
                logic [WIDTH-1:0] r_s2_g;
                logic [WIDTH-1:0] r_s2_p;
                logic [WIDTH-1:0] r_s2_x;
                logic [WIDTH:0]   w_c;

                // Stage 2: resolve and register the group carries.
                always_ff @(posedge i_clk) begin
                    if (i_rst) begin
                        r_s2_valid <= 1'b0;
                    end else if (w_advance) begin
                        r_s2_valid <= r_s1_valid;
                        r_s2_gc    <= f_group_carry(r_s1_g, r_s1_p, r_s1_cin);
                        r_s2_g     <= r_s1_g;
                        r_s2_p     <= r_s1_p;
                        r_s2_x     <= r_s1_x;
                    end
                end

                assign w_c           = f_bit_carry(r_s2_g, r_s2_p, r_s2_gc);
                assign w_result_next = {w_c[WIDTH], r_s2_x ^ w_c[WIDTH-1:0]};
                assign w_last_valid  = r_s2_valid;
`ifdef CLA_PIPE_OVF_EN
                assign w_ovf_next    = w_c[WIDTH] ^ w_c[WIDTH-1];
`endif
            end
        end
    endgenerate

    // Output stage: register the finished sum; hold it while downstream stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
`ifdef CLA_PIPE_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_advance) begin
            r_valid  <= w_last_valid;
            r_result <= w_result_next;
`ifdef CLA_PIPE_OVF_EN
            r_ovf    <= w_ovf_next;
`endif
        end
    end

    assign o_valid  = r_valid;
    assign o_result = r_result;
`ifdef CLA_PIPE_OVF_EN
    assign o_ovf    = r_ovf;
`endif

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 11, giving the operand width in bits (legal 1..64).
REQ-002 The block SHALL have parameter GROUP, default 4, giving the lookahead group size in bits (legal 1..8; the last group may be partial).
REQ-003 The block SHALL have parameter STAGES, default 2, giving the register stages from input to output (legal 1..3).
REQ-004 Port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port i_valid, input, 1 bit: operands and carry-in are valid this cycle.
REQ-007 Port o_ready, output, 1 bit: the block accepts operands this cycle.
REQ-008 Port i_add1, input, WIDTH bits: operand A, unsigned.
REQ-009 Port i_add2, input, WIDTH bits: operand B, unsigned.
REQ-010 Port i_cin, input, 1 bit: carry-in.
REQ-011 Port o_valid, output, 1 bit: o_result holds a completed sum.
REQ-012 Port i_ready, input, 1 bit: downstream accepts the result this cycle.
REQ-013 Port o_result, output, WIDTH+1 bits: the sum; the MSB is the carry-out.
REQ-014 Port o_ovf, output, 1 bit: signed-overflow flag; this port is present only when CLA_PIPE_OVF_EN is defined.

Function
REQ-015 o_result SHALL equal i_add1 + i_add2 + i_cin, zero-extended to WIDTH+1 bits, with no truncation.
REQ-016 Carries SHALL be built by carry lookahead: per-bit g = a&b and p = a|b; per-group G/P; group carry-in = G(prev) | P(prev)&c(prev); sum bit = a^b^c. No ripple across group boundaries.
REQ-017 STAGES=1: sum computed combinationally and registered; latency 1 cycle.
REQ-018 STAGES=2: stage 1 registers per-bit g/p, a^b and cin; stage 2 registers carries and sum; latency 2 cycles.
REQ-019 STAGES=3: stage 2 registers group carries; stage 3 registers the sum; latency 3 cycles.
REQ-020 Advance SHALL equal (i_ready | ~o_valid). All stages shift together only when advance=1; otherwise every stage holds.
REQ-021 o_ready SHALL equal advance, combinationally. A transfer occurs when i_valid & o_ready; on a transfer the operand is captured into stage 1 with valid=1.
REQ-022 When advance=1 and i_valid=0, a bubble (valid=0) SHALL enter stage 1.
REQ-023 Throughput SHALL be one result per cycle while i_ready=1; no result is dropped or duplicated.
REQ-024 While o_valid=1 and i_ready=0, o_result and o_valid (and o_ovf) SHALL be held stable.
REQ-025 A transfer accepted in the same cycle that a result is consumed SHALL both take effect (simultaneous in/out).
REQ-026 Boundary cases: all-ones + all-ones + cin=1 gives 2^(WIDTH+1)-1; 0+0+0 gives 0; WIDTH not a multiple of GROUP is handled by a partial top group.

Reset
REQ-027 While i_rst=1 at a clock edge: all stage valids, o_valid, o_result and o_ovf SHALL go to 0.
REQ-028 Reset asserted mid-operation SHALL discard every in-flight operand; no result for it is ever presented.
REQ-029 o_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-030 With macro CLA_PIPE_OVF_EN defined, o_ovf SHALL be output and registered in lockstep with o_result.
REQ-031 o_ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, treating the operands as two's complement.
REQ-032 Without CLA_PIPE_OVF_EN, port o_ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset/basic: defaults (WIDTH=11, GROUP=4, STAGES=2), i_rst pulse, then add 0x7FF + 0x7FF with cin=1 -> o_valid asserts 2 cycles later and o_result = 0xFFF.
REQ-034 Streaming: 8 back-to-back operand pairs with i_ready=1 -> 8 consecutive o_valid cycles, results in order, each equal to A+B+cin.
REQ-035 Backpressure: hold i_ready=0 for 5 cycles while results are pending -> o_ready=0 once the pipe is full, o_result stays stable, and all results drain in order after release with no loss.
REQ-036 Reset flush: assert i_rst with 2 operands in flight -> o_valid=0 the next cycle and no stale result appears afterward.
REQ-037 Overflow (CLA_PIPE_OVF_EN defined): 0x3FF + 0x001 -> o_ovf=1; 0x400 + 0x400 -> o_ovf=1 and o_result=0x800; 0x001 + 0x7FF -> o_ovf=0.
REQ-038 Parameter sweep: WIDTH in {1, 11, 32}, GROUP in {1, 3, 8}, STAGES in {1, 2, 3}, random operands -> results match the reference sum, and latency equals STAGES cycles.
